// File: rtl/voice_mixer_if.sv
// -----------------------------------------------------------------------------
// voice_mixer_if
// Bundles the mixer's configuration, voice-sample inputs and DAC-side outputs.
//   master : the side that supplies samples/config and observes the DAC outputs
//   slave  : the mixer itself
// Signals:
//   SAMPLE_PRESCALE  sample period minus 1, in clk cycles
//   VOICE_IN         packed offset-binary samples, voice i at [16i+15:16i]
//   VOICE_ATTEN      per-voice right-shift amount, 3 bits per voice
//   VOICE_EN         per-voice enable
//   MASTER_MUTE      forces a silent output
//   DC_OUT           PWM duty cycle (registered)
//   SAMPLE_STROBE    one-cycle pulse with each DC_OUT update
//   CLIP             last mixed sample saturated
// -----------------------------------------------------------------------------
interface voice_mixer_if #(
    parameter int NVOICE    = 4,
    parameter int DATAWIDTH = 16,
    parameter int PWM_DEPTH = 12
);
    logic [15:0]                  SAMPLE_PRESCALE;
    logic [NVOICE*DATAWIDTH-1:0]  VOICE_IN;
    logic [NVOICE*3-1:0]          VOICE_ATTEN;
    logic [NVOICE-1:0]            VOICE_EN;
    logic                         MASTER_MUTE;
    logic [PWM_DEPTH-1:0]         DC_OUT;
    logic                         SAMPLE_STROBE;
    logic                         CLIP;

    modport master (
        output SAMPLE_PRESCALE, VOICE_IN, VOICE_ATTEN, VOICE_EN, MASTER_MUTE,
        input  DC_OUT, SAMPLE_STROBE, CLIP
    );

    modport slave (
        input  SAMPLE_PRESCALE, VOICE_IN, VOICE_ATTEN, VOICE_EN, MASTER_MUTE,
        output DC_OUT, SAMPLE_STROBE, CLIP
    );
endinterface

// File: rtl/voice_mixer.sv
// -----------------------------------------------------------------------------
// voice_mixer
// Time-multiplexed audio mixer. Once per programmable sample period it snapshots
// all voice samples, accumulates them one voice per cycle with per-voice
// attenuation and enable, saturates to 16 bits and drives the PWM duty cycle.
// Samples are offset-binary (0x8000 = silence).
// Ports:
//   clk    system clock, all logic on posedge
//   rst_n  synchronous active-low reset
//   bus    voice_mixer_if slave modport (config, samples, DAC outputs)
// -----------------------------------------------------------------------------
module voice_mixer #(
    parameter int NVOICE    = 4,
    parameter int DATAWIDTH = 16,
    parameter int PWM_DEPTH = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    voice_mixer_if.slave  bus
);
    // Sum of NVOICE signed DATAWIDTH terms plus one guard bit: cannot overflow.
    localparam int ACCW = DATAWIDTH + $clog2(NVOICE) + 1;
    localparam int IDXW = (NVOICE > 1) ? $clog2(NVOICE) : 1;

    localparam logic [15:0]            P_MIN    = 16'(NVOICE + 3);
    localparam logic [DATAWIDTH-1:0]   SIGN_BIT = {1'b1, {(DATAWIDTH-1){1'b0}}};
    localparam logic [PWM_DEPTH-1:0]   DC_MID   = {1'b1, {(PWM_DEPTH-1){1'b0}}};
    localparam logic [IDXW-1:0]        IDX_LAST = IDXW'(NVOICE - 1);
    localparam logic signed [ACCW-1:0] SAT_MAX  = ACCW'((2 ** (DATAWIDTH-1)) - 1);
    localparam logic signed [ACCW-1:0] SAT_MIN  = ACCW'(-(2 ** (DATAWIDTH-1)));

    typedef enum logic [1:0] {S_IDLE, S_SNAP, S_ACC, S_OUT} state_t;

    // ------------------------------------------------------------------ timer
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] period;
    logic        tick;

    // The period is clamped so a tick can never land while a sample is in
    // flight. '>=' lets a live shrink of the prescale wrap immediately.
    assign period = (bus.SAMPLE_PRESCALE > P_MIN) ? bus.SAMPLE_PRESCALE : P_MIN;
    assign tick   = (cnt_q >= period);
    assign cnt_d  = tick ? 16'd0 : cnt_q + 16'd1;

    // NOTE: sequential state is always updated with non-blocking assignments so
    // every register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // ------------------------------------------------------- shadow registers
    logic [DATAWIDTH-1:0] voice_q [NVOICE];
    logic [2:0]           atten_q [NVOICE];
    logic [NVOICE-1:0]    en_q;
    state_t               state_q;

    // NOTE: the shadow registers carry no reset; they are always rewritten in
    // SNAP before ACC reads them, so resetting them would only add logic.
    always_ff @(posedge clk) begin
        if (state_q == S_SNAP) begin
            for (int i = 0; i < NVOICE; i++) begin
                voice_q[i] <= bus.VOICE_IN[i*DATAWIDTH +: DATAWIDTH];
                atten_q[i] <= bus.VOICE_ATTEN[i*3 +: 3];
            end
            en_q <= bus.VOICE_EN;
        end
    end

    // ------------------------------------------------------- per-voice term
    logic [IDXW-1:0]              idx_q;
    logic signed [ACCW-1:0]       acc_q;
    logic signed [DATAWIDTH-1:0]  s_cur, t_cur;
    logic signed [ACCW-1:0]       term;

    assign s_cur = signed'(voice_q[idx_q] ^ SIGN_BIT);   // offset-binary -> two's complement
    assign t_cur = s_cur >>> atten_q[idx_q];
    assign term  = en_q[idx_q] ? ACCW'(t_cur) : '0;

    // ------------------------------------------------ saturate and convert
    logic [PWM_DEPTH-1:0] dc_d;
    logic                 clip_d;

    // NOTE: every output of this always_comb gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        clip_d = 1'b0;
        // Flipping the sign bit of the 16-bit result gives offset binary; only
        // its top PWM_DEPTH bits reach the DAC.
        dc_d   = {~acc_q[DATAWIDTH-1], acc_q[DATAWIDTH-2 -: PWM_DEPTH-1]};
        if (acc_q > SAT_MAX) begin
            clip_d = 1'b1;
            dc_d   = '1;
        end else if (acc_q < SAT_MIN) begin
            clip_d = 1'b1;
            dc_d   = '0;
        end
    end

    // ------------------------------------------------------------------- FSM
    logic [PWM_DEPTH-1:0] dc_q;
    logic                 strobe_q;
    logic                 clip_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            idx_q    <= '0;
            dc_q     <= DC_MID;
            strobe_q <= 1'b0;
            clip_q   <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            case (state_q)
                S_IDLE: if (tick) state_q <= S_SNAP;
                S_SNAP: begin
                    acc_q   <= '0;
                    idx_q   <= '0;
                    state_q <= S_ACC;
                end
                S_ACC: begin
                    acc_q <= acc_q + term;
                    if (idx_q == IDX_LAST) state_q <= S_OUT;
                    else                   idx_q   <= idx_q + 1'b1;
                end
                S_OUT: begin
                    strobe_q <= 1'b1;
                    if (bus.MASTER_MUTE) begin
                        dc_q   <= DC_MID;
                        clip_q <= 1'b0;
                    end else begin
                        dc_q   <= dc_d;
                        clip_q <= clip_d;
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.DC_OUT        = dc_q;
    assign bus.SAMPLE_STROBE = strobe_q;
    assign bus.CLIP          = clip_q;
endmodule

// File: tb/tb_voice_mixer.sv
// -----------------------------------------------------------------------------
// tb_voice_mixer
// Self-checking bench for voice_mixer (NVOICE=4): reset/strobe timing, a table
// of directed mix vectors, coherent capture, mid-sample reset, randomized
// vectors against an arithmetic reference model, and the prescale clamp.
// -----------------------------------------------------------------------------
module tb_voice_mixer;
    localparam int NV = 4;

    typedef struct packed {
        logic [63:0] v;      // voice i at [16i+15:16i]
        logic [11:0] a;      // atten i at [3i+2:3i]
        logic [3:0]  en;
        logic        mute;
        logic [11:0] dc;     // expected DC_OUT
        logic        clip;   // expected CLIP
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    voice_mixer_if #(.NVOICE(NV), .DATAWIDTH(16), .PWM_DEPTH(12)) ifc ();

    voice_mixer #(.NVOICE(NV), .DATAWIDTH(16), .PWM_DEPTH(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the mixing rules.
    function automatic int floor_div(input int x, input int d);
        if (x >= 0) return x / d;
        return -((-x + d - 1) / d);
    endfunction

    function automatic void model(input vec_t t, output logic [11:0] dc, output logic clip);
        int sum = 0;
        int s;
        for (int i = 0; i < NV; i++) begin
            if (t.en[i]) begin
                s = int'(t.v[16*i +: 16]) - 32768;
                sum += floor_div(s, 1 << int'(t.a[3*i +: 3]));
            end
        end
        clip = (sum > 32767) || (sum < -32768);
        if (sum > 32767)  sum = 32767;
        if (sum < -32768) sum = -32768;
        dc = 12'((sum + 32768) / 16);
        if (t.mute) begin
            dc   = 12'h800;
            clip = 1'b0;
        end
    endfunction

    task automatic apply(input vec_t t);
        ifc.VOICE_IN    = t.v;
        ifc.VOICE_ATTEN = t.a;
        ifc.VOICE_EN    = t.en;
        ifc.MASTER_MUTE = t.mute;
    endtask

    // Steps negedges until a strobe is seen (or the limit expires); n is the
    // number of cycles waited. Outputs must not move between strobes.
    task automatic wait_strobe(input int limit, output int n);
        logic [11:0] dc0  = ifc.DC_OUT;
        logic        clp0 = ifc.CLIP;
        logic        moved = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!ifc.SAMPLE_STROBE && (ifc.DC_OUT !== dc0 || ifc.CLIP !== clp0))
                moved = 1'b1;
        end while (!ifc.SAMPLE_STROBE && n < limit);
        if (!ifc.SAMPLE_STROBE) check("strobe_timeout", 32'(ifc.SAMPLE_STROBE), 32'd1);
        check("hold_between_strobes", 32'(moved), 32'd0);
    endtask

    vec_t tbl [8];
    vec_t rv;
    int   n;
    logic [11:0] exp_dc;
    logic        exp_clip;

    initial begin
        // Directed vectors with hand-derived expectations.
        tbl[0] = '{v: {4{16'h8000}}, a: '0, en: 4'hF, mute: 1'b0, dc: 12'h800, clip: 1'b0};
        tbl[1] = '{v: {16'h1234, 16'h1234, 16'h1234, 16'hC000}, a: 12'o0001, en: 4'h1,
                   mute: 1'b0, dc: 12'hA00, clip: 1'b0};
        tbl[2] = '{v: {16'h1234, 16'h1234, 16'h1234, 16'h0000}, a: 12'o0002, en: 4'h1,
                   mute: 1'b0, dc: 12'h600, clip: 1'b0};
        tbl[3] = '{v: {4{16'hFFFF}}, a: '0, en: 4'hF, mute: 1'b0, dc: 12'hFFF, clip: 1'b1};
        tbl[4] = '{v: {4{16'h0000}}, a: '0, en: 4'hF, mute: 1'b0, dc: 12'h000, clip: 1'b1};
        tbl[5] = '{v: {4{16'h8000}}, a: '0, en: 4'hF, mute: 1'b0, dc: 12'h800, clip: 1'b0};
        tbl[6] = '{v: {4{16'hFFFF}}, a: '0, en: 4'hF, mute: 1'b1, dc: 12'h800, clip: 1'b0};
        tbl[7] = '{v: {4{16'hFFFF}}, a: '0, en: 4'h0, mute: 1'b0, dc: 12'h800, clip: 1'b0};

        // ---------------------------------------------------------- reset
        rst_n = 1'b0;
        ifc.SAMPLE_PRESCALE = 16'd20;
        apply(tbl[0]);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dc", 32'(ifc.DC_OUT), 32'h800);
        check("rst_clip", 32'(ifc.CLIP), 32'd0);
        check("rst_strobe", 32'(ifc.SAMPLE_STROBE), 32'd0);
        rst_n = 1'b1;
        wait_strobe(200, n);
        check("first_strobe_cycle", 32'(n), 32'd27);
        wait_strobe(200, n);
        check("strobe_period_21", 32'(n), 32'd21);
        check("silence_dc", 32'(ifc.DC_OUT), 32'h800);
        @(negedge clk);
        check("strobe_one_cycle", 32'(ifc.SAMPLE_STROBE), 32'd0);
        wait_strobe(200, n);

        // ------------------------------------------------ directed table
        for (int i = 0; i < 8; i++) begin
            apply(tbl[i]);
            wait_strobe(200, n);
            wait_strobe(200, n);
            check($sformatf("vec%0d_dc", i), 32'(ifc.DC_OUT), 32'(tbl[i].dc));
            check($sformatf("vec%0d_clip", i), 32'(ifc.CLIP), 32'(tbl[i].clip));
        end

        // ------------------------------------------- coherent capture
        // Strobe at T+7, next tick at T+21; inputs change in T'+2 (first ACC).
        apply(tbl[1]);
        wait_strobe(200, n);
        wait_strobe(200, n);
        repeat (16) @(negedge clk);
        apply(tbl[2]);
        wait_strobe(200, n);
        check("capture_latency", 32'(n), 32'd5);
        check("capture_old", 32'(ifc.DC_OUT), 32'hA00);
        wait_strobe(200, n);
        check("capture_new", 32'(ifc.DC_OUT), 32'h600);

        // ------------------------------------------ mid-sample reset
        apply(tbl[3]);
        wait_strobe(200, n);
        wait_strobe(200, n);
        check("pre_reset_dc", 32'(ifc.DC_OUT), 32'hFFF);
        repeat (17) @(negedge clk);          // second ACC cycle of the next sample
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_dc", 32'(ifc.DC_OUT), 32'h800);
        check("midrst_clip", 32'(ifc.CLIP), 32'd0);
        check("midrst_strobe", 32'(ifc.SAMPLE_STROBE), 32'd0);
        rst_n = 1'b1;
        wait_strobe(200, n);
        check("midrst_restart_cycle", 32'(n), 32'd27);

        // ----------------------------------------------- randomized
        for (int k = 0; k < 24; k++) begin
            rv      = '0;
            rv.v    = {$urandom, $urandom};
            rv.a    = 12'($urandom);
            rv.en   = 4'($urandom);
            rv.mute = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) rv.v = {4{16'($urandom_range(0, 1) != 0 ? 16'hF000 : 16'h0800)}};
            ifc.SAMPLE_PRESCALE = 16'($urandom_range(0, 30));
            model(rv, exp_dc, exp_clip);
            apply(rv);
            wait_strobe(200, n);
            wait_strobe(200, n);
            check($sformatf("rand%0d_dc", k), 32'(ifc.DC_OUT), 32'(exp_dc));
            check($sformatf("rand%0d_clip", k), 32'(ifc.CLIP), 32'(exp_clip));
        end

        // ------------------------------------ prescale clamp and mute
        ifc.SAMPLE_PRESCALE = 16'd0;
        apply(tbl[6]);
        wait_strobe(200, n);
        wait_strobe(200, n);
        check("clamp_period_8", 32'(n), 32'd8);
        check("mute_dc", 32'(ifc.DC_OUT), 32'h800);
        check("mute_clip", 32'(ifc.CLIP), 32'd0);
        wait_strobe(200, n);
        check("clamp_period_8b", 32'(n), 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
